// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, forward S-box table and SubBytes FSM states
package aes_pkg;

   localparam int AES_STATE_W   = 128;
   localparam int AES_NCOLS     = 4;
   localparam int AES_COL_W     = AES_STATE_W / AES_NCOLS;
   localparam int AES_COL_IDX_W = 2;
   localparam logic [AES_COL_IDX_W-1:0] COL_LAST = AES_COL_IDX_W'(AES_NCOLS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sb_state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup, one byte lane
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   assign dout = SBOX[din];

endmodule

// File: rtl/sub_bytes_iter.sv
// rtl/sub_bytes_iter.sv - iterative AES SubBytes, one 32-bit column per cycle through four S-box lanes
module sub_bytes_iter
   import aes_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] data_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] data_out
);

   sb_state_t                state, state_nxt;
   logic [AES_COL_IDX_W-1:0] col;
   logic [AES_STATE_W-1:0]   work;
   logic [AES_COL_W-1:0]     col_word;
   logic [AES_COL_W-1:0]     col_sub;
   logic                     load;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = BUSY;
         BUSY:    if (col == COL_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready follows out_ready in DONE so a new state can load on the same edge the result leaves
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = rst_n;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = rst_n && out_ready;
         end
         default: ;
      endcase
   end

   assign load = in_valid && in_ready;

   always_comb begin
      col_word = '0;
      case (col)
         2'd0: col_word = work[127:96];
         2'd1: col_word = work[95:64];
         2'd2: col_word = work[63:32];
         2'd3: col_word = work[31:0];
         default: col_word = '0;
      endcase
   end

   for (genvar g = 0; g < 4; g++) begin : g_lane
      aes_sbox u_sbox (
         .din  (col_word[AES_COL_W-1-8*g -: 8]),
         .dout (col_sub[AES_COL_W-1-8*g -: 8])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work <= '0;
         col  <= '0;
      end else if (load) begin
         work <= data_in;
         col  <= '0;
      end else if (state == BUSY) begin
         case (col)
            2'd0: work[127:96] <= col_sub;
            2'd1: work[95:64]  <= col_sub;
            2'd2: work[63:32]  <= col_sub;
            2'd3: work[31:0]   <= col_sub;
            default: ;
         endcase
         col <= col + 2'd1;
      end
   end

   assign data_out = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// tb/tb_sub_bytes_iter.sv - self-checking bench for sub_bytes_iter against a GF(2^8) SubBytes model
module tb_sub_bytes_iter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic         in_ready;
   logic         out_valid;
   logic [127:0] data_in = '0;
   logic [127:0] data_out;

   int           checks = 0;
   int           errors = 0;
   logic [7:0]   sb [256];
   logic [127:0] exp_q [$];

   always #5 clk = ~clk;

   sub_bytes_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out)
   );

   function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl(logic [7:0] x, int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   // S-box from its definition: multiplicative inverse in GF(2^8) followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
         sb[v] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] sub_bytes(logic [127:0] s);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sb[s[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(output logic acc, output logic got, output logic [127:0] dat);
      @(negedge clk);
      acc = in_valid && in_ready;
      got = out_valid && out_ready;
      dat = data_out;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string tag);
      logic a, g;
      logic [127:0] d;
      int n = 0;
      do begin
         tick(a, g, d);
         n++;
      end while (!a && n < 20);
      check(tag, 128'(a), 128'(1));
   endtask

   // returns at the negedge where out_valid is first seen; lat counts edges since the accept
   task automatic wait_valid(output int lat);
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_one(input string tag, input logic [127:0] din, output logic [127:0] dout, output int lat);
      in_valid  = 1'b1;
      data_in   = din;
      out_ready = 1'b1;
      wait_accept({tag, "_accept"});
      in_valid = 1'b0;
      wait_valid(lat);
      dout = data_out;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] vec [5];
      logic [127:0] kat [5];
      logic [127:0] res, a_state, b2b_in [3], b2b_out [3];
      logic         a, g;
      logic [127:0] d;
      int           lat, n_acc, n_out, sent, rcvd, cyc, hs;
      int           acc_t [3], out_t [3];

      build_sbox();

      // reset state, with in_valid high to see in_ready gated
      rst_n    = 1'b0;
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_data_out", data_out, 128'h0);
      check("rst_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;

      // directed vectors: FIPS-197 round 1, all-zero, all-ones, 00..ff ramp, all-0x53
      vec[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; kat[0] = 128'hd42711aee0bf98f1b8b45de51e415230;
      vec[1] = {16{8'h00}};                           kat[1] = {16{8'h63}};
      vec[2] = {16{8'hff}};                           kat[2] = {16{8'h16}};
      vec[3] = 128'h00112233445566778899aabbccddeeff; kat[3] = 128'h638293c31bfc33f5c4eeacea4bc12816;
      vec[4] = {16{8'h53}};                           kat[4] = {16{8'hed}};
      for (int i = 0; i < 5; i++) begin
         run_one($sformatf("vec%0d", i), vec[i], res, lat);
         check($sformatf("vec%0d_latency", i), 128'(lat), 128'(4));
         check($sformatf("vec%0d_kat", i), res, kat[i]);
         check($sformatf("vec%0d_model", i), res, sub_bytes(vec[i]));
         check($sformatf("vec%0d_idle_after", i), 128'(out_valid), 128'(0));
      end

      // backpressure: hold result for 10 cycles while a second state waits
      a_state   = rand128();
      in_valid  = 1'b1;
      data_in   = a_state;
      out_ready = 1'b0;
      wait_accept("bp_accept");
      data_in = rand128();
      wait_valid(lat);
      check("bp_latency", 128'(lat), 128'(4));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_data_out", data_out, sub_bytes(a_state));
         check("bp_in_ready", 128'(in_ready), 128'(0));
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_valid", 128'(out_valid), 128'(0));
      check("bp_release_ready", 128'(in_ready), 128'(1));
      hs = 0;
      for (int i = 0; i < 6; i++) begin
         tick(a, g, d);
         if (g) hs++;
      end
      check("bp_no_hidden_accept", 128'(hs), 128'(0));

      // back-to-back: accepts on edges 0,5,10; result handshakes on 5,10,15 (out_valid up after 4,9,14)
      for (int i = 0; i < 3; i++) b2b_in[i] = rand128();
      n_acc     = 0;
      n_out     = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      data_in   = b2b_in[0];
      for (int t = 0; t < 20; t++) begin
         tick(a, g, d);
         if (g && n_out < 3) begin
            out_t[n_out]   = t;
            b2b_out[n_out] = d;
            n_out++;
         end
         if (a && n_acc < 3) begin
            acc_t[n_acc] = t;
            n_acc++;
            if (n_acc < 3) data_in = b2b_in[n_acc];
            else           in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("b2b_n_acc", 128'(n_acc), 128'(3));
      check("b2b_n_out", 128'(n_out), 128'(3));
      for (int i = 0; i < 3; i++) begin
         if (i < n_acc) check($sformatf("b2b_acc%0d_cycle", i), 128'(acc_t[i]), 128'(5*i));
         if (i < n_out) begin
            check($sformatf("b2b_out%0d_cycle", i), 128'(out_t[i] - 1), 128'(4 + 5*i));
            check($sformatf("b2b_out%0d_data", i), b2b_out[i], sub_bytes(b2b_in[i]));
         end
      end

      // reset while BUSY with col==2
      in_valid  = 1'b1;
      data_in   = rand128();
      out_ready = 1'b1;
      wait_accept("rstmid_accept");
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
      check("rstmid_out_valid", 128'(out_valid), 128'(0));
      check("rstmid_data_out", data_out, 128'h0);
      rst_n = 1'b1;
      hs = 0;
      for (int i = 0; i < 8; i++) begin
         tick(a, g, d);
         if (g) hs++;
      end
      check("rstmid_no_output", 128'(hs), 128'(0));
      a_state = rand128();
      run_one("rstmid_fresh", a_state, res, lat);
      check("rstmid_fresh_latency", 128'(lat), 128'(4));
      check("rstmid_fresh_data", res, sub_bytes(a_state));

      // random traffic with stalls on both sides
      exp_q.delete();
      sent    = 0;
      rcvd    = 0;
      cyc     = 0;
      data_in = rand128();
      while (rcvd < 1000 && cyc < 40000) begin
         in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
         out_ready = ($urandom_range(3) != 0);
         tick(a, g, d);
         cyc++;
         if (a) begin
            exp_q.push_back(sub_bytes(data_in));
            sent++;
            data_in = rand128();
         end
         if (g) begin
            if (exp_q.size() == 0) check("rand_spurious_output", d, 128'hx);
            else                   check("rand_data", d, exp_q.pop_front());
            rcvd++;
         end
      end
      in_valid = 1'b0;
      check("rand_count", 128'(rcvd), 128'(1000));
      check("rand_queue_empty", 128'(exp_q.size()), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
